fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write arbiter that shares the write port of one `regb_fifo` instance between `REQ` independent producers. Each producer offers words over a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and drives the FIFO's `shift_in`/`wdata` pair, honouring `full`. It sits directly in front of the FIFO write side; the read side (`shift_out`/`rdata`/`empty`) is not touched.

## Interface
- `WIDTH`, 16, data word width; matches the FIFO `WIDTH`.
- `REQ`, 4, number of producers, 2..8.
- `MAX_BURST`, 4, maximum words accepted per grant, 1..15.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `res_n`  in  1  reset; asynchronous assert, active-low.
- `req_valid`  in  REQ  producer i holds a word on its data slice.
- `req_data`  in  REQ*WIDTH  packed producer words; slice i is `[i*WIDTH +: WIDTH]`.
- `req_ready`  out  REQ  one-hot or zero; word i is consumed on the clock edge where `req_valid[i] & req_ready[i]`.
- `fifo_full`  in  1  FIFO `full`.
- `fifo_shift_in`  out  1  FIFO `shift_in`.
- `fifo_wdata`  out  WIDTH  FIFO `wdata`.
- `grant`  out  REQ  registered one-hot current owner; all zero when idle.
- `busy`  out  1  high while in state GRANT.

## Operation
- There are two states, IDLE and GRANT. Registers: `owner` (clog2(REQ) bits), `ptr` (clog2(REQ) bits), and `burst_cnt` (4 bits).
- **IDLE:**
  - If any `req_valid` is high, search cyclically from index `ptr` upward, wrapping modulo REQ. The first valid index becomes `owner`.
  - On that edge: `grant` is set to one-hot(`owner`), `burst_cnt` to 0, and the state to GRANT.
  - With no requests, stay in IDLE.
- **GRANT, transfer condition** `xfer = req_valid[owner] & ~fifo_full`:
  - `fifo_shift_in = xfer`.
  - `req_ready[owner] = ~fifo_full`; all other `req_ready` bits are 0.
  - `fifo_wdata = req_data[owner]` while in GRANT, and 0 otherwise.
- **GRANT, leaving the state:**
  - On a transfer, `burst_cnt` increments. If it reaches `MAX_BURST` on this edge, go to IDLE.
  - If `req_valid[owner]` is low, go to IDLE on this edge with no transfer. This is a voluntary release.
  - On either exit, `ptr` is set to (`owner`+1) mod REQ and `grant` is cleared.
- `fifo_full` high in GRANT stalls: no transfer, `burst_cnt` is held, and the grant is kept. A stall never causes a release.
- Non-owners never see `req_ready` high. Their words stay pending with no loss or duplication.
- Producers must hold `req_data` stable while `req_valid` is high and not yet accepted.

## Timing
- Reset (`res_n` low, asynchronous) gives:
  - state IDLE, `ptr` = 0, `owner` = 0, `burst_cnt` = 0;
  - `grant` = 0, `busy` = 0;
  - `req_ready` = 0, `fifo_shift_in` = 0, `fifo_wdata` = 0.
- Reset asserted mid-burst aborts the burst immediately. Words already shifted stay in the FIFO; no partial word is written.
- Arbitration latency is 1 cycle: a request seen in IDLE at edge N gives `grant` and `busy` high after edge N, and the first transfer can occur at edge N+1.
- Every release costs one IDLE cycle. Peak throughput is `MAX_BURST` words per `MAX_BURST`+1 cycles.
- `fifo_shift_in`, `req_ready` and `fifo_wdata` are combinational from registered state plus `req_valid[owner]`, `req_data` and `fifo_full`. There is no combinational path from `fifo_full` to `grant`.
- `fifo_full` rising at edge N:
  - `fifo_shift_in` is low for the following cycle, so the arbiter never writes into a full FIFO.
  - When `full` falls, transfers resume in the same cycle.
- `ptr` wraps from REQ-1 to 0.
- A requester that raises `req_valid` in the same cycle another is released competes at the next IDLE evaluation from the updated `ptr`.
- Fairness bound: a continuously requesting producer is granted within REQ-1 other grants.

## Test plan
- **Reset and idle:** hold `res_n`=0 for 2 cycles, then release with no requests.
  - All outputs stay 0 and `busy`=0 for 10 cycles.
- **Single requester, depth-5 FIFO, `MAX_BURST`=4:** producer 2 streams 0x1000..0x1005.
  - Grant after 1 cycle, then 4 writes, 1 IDLE cycle, then a new grant to producer 2.
  - The FIFO fills after 5 words and `fifo_shift_in` stays low while `full`.
  - Draining with `shift_out` yields 0x1000..0x1004 in order; 0x1005 follows after resume.
- **All four producers requesting continuously, FIFO drained every cycle:**
  - Grant order is 0,1,2,3,0 with 4 words each.
  - Each producer's words appear contiguously and in order; 16 words are written in 20 cycles.
- **Voluntary release:** producer 1 sends 2 words, then drops `req_valid`; producer 3 is waiting.
  - Producer 1's grant ends after 2 words and `ptr` becomes 2.
  - Producer 3 is granted next cycle.
- **Full stall mid-burst:** force `fifo_full`=1 for 3 cycles after the 2nd word of a burst.
  - `req_ready` and `fifo_shift_in` are 0 for those cycles and `burst_cnt` holds at 2.
  - The burst completes with exactly 4 words and none is lost.
- **Reset mid-burst:** assert `res_n`=0 asynchronously between edges during a transfer.
  - Outputs go to 0 immediately.
  - After release, arbitration restarts from `ptr`=0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port between REQ producers.
// Grants one producer at a time for up to MAX_BURST words, honouring fifo_full.
module fifo_wr_arbiter #(
   parameter int WIDTH     = 16,
   parameter int REQ       = 4,
   parameter int MAX_BURST = 4
) (
   input  logic                 clk,
   input  logic                 res_n,
   input  logic [REQ-1:0]       req_valid,
   input  logic [REQ*WIDTH-1:0] req_data,
   output logic [REQ-1:0]       req_ready,
   input  logic                 fifo_full,
   output logic                 fifo_shift_in,
   output logic [WIDTH-1:0]     fifo_wdata,
   output logic [REQ-1:0]       grant,
   output logic                 busy
);

   localparam int IW = $clog2(REQ);

   typedef enum logic {S_IDLE, S_GRANT} state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [3:0]      burst_q, burst_d;
   logic [REQ-1:0]  grant_q, grant_d;

   logic            own_valid;
   logic [WIDTH-1:0] own_data;
   logic            found;
   logic [IW-1:0]   next_owner;
   logic [IW-1:0]   release_ptr;

   // Current owner's request and data word
   always_comb begin
      own_valid = 1'b0;
      own_data  = '0;
      for (int unsigned i = 0; i < REQ; i++) begin
         if (owner_q == IW'(i)) begin
            own_valid = req_valid[i];
            own_data  = req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Cyclic search starting at ptr_q, first valid index wins
   always_comb begin
      found      = 1'b0;
      next_owner = ptr_q;
      for (int unsigned k = 0; k < REQ; k++) begin
         for (int unsigned j = 0; j < REQ; j++) begin
            if (!found && req_valid[j] && (j == (32'(ptr_q) + k) % REQ)) begin
               found      = 1'b1;
               next_owner = IW'(j);
            end
         end
      end
      release_ptr = (owner_q == IW'(REQ-1)) ? '0 : owner_q + 1'b1;
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q <= S_IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         burst_q <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         burst_q <= burst_d;
         grant_q <= grant_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      burst_d = burst_q;
      grant_d = grant_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d = S_GRANT;
               owner_d = next_owner;
               burst_d = '0;
               for (int unsigned i = 0; i < REQ; i++) begin
                  grant_d[i] = (next_owner == IW'(i));
               end
            end
         end
         S_GRANT: begin
            if (!own_valid) begin
               state_d = S_IDLE;
               ptr_d   = release_ptr;
               grant_d = '0;
            end else if (!fifo_full) begin
               burst_d = burst_q + 4'd1;
               if (burst_q + 4'd1 == 4'(MAX_BURST)) begin
                  state_d = S_IDLE;
                  ptr_d   = release_ptr;
                  grant_d = '0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy          = (state_q == S_GRANT);
      grant         = grant_q;
      req_ready     = '0;
      fifo_shift_in = 1'b0;
      fifo_wdata    = '0;
      if (state_q == S_GRANT) begin
         for (int unsigned i = 0; i < REQ; i++) begin
            req_ready[i] = (owner_q == IW'(i)) & ~fifo_full;
         end
         fifo_shift_in = own_valid & ~fifo_full;
         fifo_wdata    = own_data;
      end
   end

endmodule
